// File: rtl/tx_frame_loader_pkg.sv
// Shared types and defaults for the transmit frame loader.
// Slot, loader and sender state encodings plus the BRAM address width.
package tx_frame_loader_pkg;
  localparam int AW             = 11;
  localparam int SLOT_WORDS_DEF = 1024;
  localparam int MAX_FRAME_DEF  = 1024;
  localparam int MIN_FRAME_DEF  = 60;

  typedef enum logic [1:0] {S_FREE, S_FILLING, S_READY, S_SENDING} slot_st_e;
  typedef enum logic [1:0] {L_IDLE, L_FILL, L_PAD, L_DONE} ld_st_e;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_BUSY} sd_st_e;

  function automatic logic [AW-1:0] slot_base(input logic ptr, input int slot_words);
    return ptr ? AW'(slot_words) : '0;
  endfunction
endpackage

// File: rtl/tx_frame_loader_if.sv
// Byte stream in, BRAM write port and send-request lane out, engine busy back.
// slave = loader, master = feeder/engine side.
interface tx_frame_loader_if;
  import tx_frame_loader_pkg::*;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic [AW-1:0] wraddr;
  logic [15:0]   wrdata;
  logic          send_pack_valid;
  logic [AW-1:0] send_pack_addr;
  logic [AW-1:0] send_pack_size;
  logic          send_pack_index;
  logic          txbusy;
  logic          trunc;

  modport master (
    output in_valid, in_data, in_last, txbusy,
    input  in_ready, wraddr, wrdata, send_pack_valid, send_pack_addr,
           send_pack_size, send_pack_index, trunc
  );
  modport slave (
    input  in_valid, in_data, in_last, txbusy,
    output in_ready, wraddr, wrdata, send_pack_valid, send_pack_addr,
           send_pack_size, send_pack_index, trunc
  );
endinterface

// File: rtl/tx_frame_loader.sv
// Ping-pong frame loader feeding the MII transmit engine's packet BRAM.
// Define TX_FRAME_LOADER_PAD_EN to zero-pad short frames up to MIN_FRAME.
module tx_frame_loader
  import tx_frame_loader_pkg::*;
#(
  parameter int SLOT_WORDS = SLOT_WORDS_DEF,
  parameter int MAX_FRAME  = MAX_FRAME_DEF,
  parameter int MIN_FRAME  = MIN_FRAME_DEF
) (
  input logic              clk,
  input logic              arst,
  tx_frame_loader_if.slave bus
);
  localparam logic [AW-1:0] MAX_K = AW'(MAX_FRAME);
`ifdef TX_FRAME_LOADER_PAD_EN
  localparam logic [AW-1:0] MIN_K = AW'(MIN_FRAME);
`endif

  slot_st_e      slot_st   [2];
  logic [AW-1:0] slot_size [2];
  logic          fill_ptr, send_ptr;
  ld_st_e        ld_st;
  sd_st_e        sd_st;
  logic [AW-1:0] k, k_inc;
  logic          k_sat, ovf, accept;
  logic          rdy_q, trunc_q, spv_q;
  logic [AW-1:0] wraddr_q, spa_q, sps_q;
  logic [15:0]   wrdata_q;
  logic [AW-1:0] fill_base, send_base;

  assign fill_base = slot_base(fill_ptr, SLOT_WORDS);
  assign send_base = slot_base(send_ptr, SLOT_WORDS);
  assign accept    = bus.in_valid && rdy_q;
  assign k_sat     = (k == MAX_K);
  assign k_inc     = k_sat ? k : k + 1'b1;

  always_ff @(posedge clk) begin
    if (!arst) begin
      slot_st[0]   <= S_FREE;
      slot_st[1]   <= S_FREE;
      slot_size[0] <= '0;
      slot_size[1] <= '0;
      fill_ptr <= 1'b0;
      send_ptr <= 1'b0;
      ld_st    <= L_IDLE;
      sd_st    <= D_IDLE;
      k        <= '0;
      ovf      <= 1'b0;
      rdy_q    <= 1'b0;
      trunc_q  <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      spv_q    <= 1'b0;
      spa_q    <= '0;
      sps_q    <= '0;
    end else begin
      trunc_q <= 1'b0;
      case (ld_st)
        L_IDLE: if (slot_st[fill_ptr] == S_FREE) begin
          slot_st[fill_ptr] <= S_FILLING;
          k     <= '0;
          ovf   <= 1'b0;
          rdy_q <= 1'b1;
          ld_st <= L_FILL;
        end
        L_FILL: if (accept) begin
          // Past MAX_FRAME bytes are swallowed so the feeder never stalls.
          if (!k_sat) begin
            wraddr_q <= fill_base + k;
            wrdata_q <= {2{bus.in_data}};
            k        <= k + 1'b1;
          end
          if (bus.in_last) begin
            rdy_q   <= 1'b0;
            trunc_q <= ovf | k_sat;
`ifdef TX_FRAME_LOADER_PAD_EN
            ld_st   <= (k_inc < MIN_K) ? L_PAD : L_DONE;
`else
            ld_st   <= L_DONE;
`endif
          end else begin
            ovf <= ovf | k_sat;
          end
        end
`ifdef TX_FRAME_LOADER_PAD_EN
        L_PAD: begin
          wraddr_q <= fill_base + k;
          wrdata_q <= '0;
          k        <= k_inc;
          if (k_inc == MIN_K) ld_st <= L_DONE;
        end
`endif
        L_DONE: begin
          slot_st[fill_ptr]   <= S_READY;
          slot_size[fill_ptr] <= k;
          fill_ptr            <= ~fill_ptr;
          ld_st               <= L_IDLE;
        end
        default: ld_st <= L_IDLE;
      endcase

      // addr/size stay put through BUSY: the engine reads them while on the wire.
      case (sd_st)
        D_IDLE: if (slot_st[send_ptr] == S_READY) begin
          slot_st[send_ptr] <= S_SENDING;
          spa_q <= send_base;
          sps_q <= slot_size[send_ptr];
          spv_q <= 1'b1;
          sd_st <= D_REQ;
        end
        D_REQ: if (bus.txbusy) begin
          spv_q <= 1'b0;
          sd_st <= D_BUSY;
        end
        D_BUSY: if (!bus.txbusy) begin
          slot_st[send_ptr] <= S_FREE;
          send_ptr          <= ~send_ptr;
          sd_st             <= D_IDLE;
        end
        default: sd_st <= D_IDLE;
      endcase
    end
  end

  assign bus.in_ready        = rdy_q;
  assign bus.wraddr          = wraddr_q;
  assign bus.wrdata          = wrdata_q;
  assign bus.send_pack_valid = spv_q;
  assign bus.send_pack_addr  = spa_q;
  assign bus.send_pack_size  = sps_q;
  assign bus.send_pack_index = 1'b0;
  assign bus.trunc           = trunc_q;
endmodule
